// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the 4-digit BCD counter.
package bcd_counter_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Clamp any non-decimal nibble to 9 so a digit can never leave 0..9.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade up/down cell with enable-in, carry/borrow-out and preset.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic       clk_50MHz,
    input  logic       reset_button,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       enable,
    input  logic       up_down,
    output logic [3:0] digit,
    output logic       terminal
);

    // Terminal value is 9 when counting up, 0 when counting down.
    always_comb begin
        terminal = up_down ? (digit == BCD_MAX) : (digit == BCD_MIN);
    end

    // Digit register: reset > clear > load > enabled step.
    always_ff @(posedge clk_50MHz) begin
        if (reset_button) begin
            digit <= BCD_MIN;
        end else if (clear) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= load_digit;
        end else if (enable) begin
            if (up_down) begin
                digit <= terminal ? BCD_MIN : digit + 4'd1;
            end else begin
                digit <= terminal ? BCD_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4digit.sv
// Four-digit BCD up/down counter with prescaler, run/stop FSM, clear and preset.
module bcd_counter_4digit
    import bcd_counter_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk_50MHz,
    input  logic        reset_button,
    input  logic        start_stop,
    input  logic        up_down,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        running,
    output logic        tick,
    output logic        carry
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    run_state_t    state;
    logic          start_prev;
    logic [PW-1:0] presc;
    logic          start_rise;
    logic          step;
    logic [3:0]    digit_en;
    logic [3:0]    digit_term;
    logic          wrap;

    // Step occurs on the prescaler's terminal count unless clear/load overrides it.
    always_comb begin
        start_rise = start_stop & ~start_prev;
        step       = (state == RUNNING) && (presc == PRESC_LAST) && !clear && !load;
        digit_en   = '0;
        digit_en[0] = step;
        for (int unsigned i = 1; i < 4; i++) begin
            digit_en[i] = digit_en[i-1] & digit_term[i-1];
        end
        wrap = digit_en[3] & digit_term[3];
    end

    // Run FSM, prescaler and registered tick/carry pulses.
    always_ff @(posedge clk_50MHz) begin
        if (reset_button) begin
            state      <= STOPPED;
            start_prev <= 1'b0;
            presc      <= '0;
            tick       <= 1'b0;
            carry      <= 1'b0;
        end else begin
            start_prev <= start_stop;
            if (start_rise) begin
                state <= (state == RUNNING) ? STOPPED : RUNNING;
            end
            if (clear || load) begin
                presc <= '0;
                tick  <= 1'b0;
                carry <= 1'b0;
            end else if (state == RUNNING) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                    carry <= wrap;
                end else begin
                    presc <= presc + PW'(1);
                    tick  <= 1'b0;
                    carry <= 1'b0;
                end
            end else begin
                tick  <= 1'b0;
                carry <= 1'b0;
            end
        end
    end

    assign running = (state == RUNNING);

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_50MHz   (clk_50MHz),
            .reset_button(reset_button),
            .clear       (clear),
            .load        (load),
            .load_digit  (sanitize_digit(load_val[4*g +: 4])),
            .enable      (digit_en[g]),
            .up_down     (up_down),
            .digit       (bcd[4*g +: 4]),
            .terminal    (digit_term[g])
        );
    end

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// Directed self-checking bench for bcd_counter_4digit with TICK_DIV=4.
module tb_bcd_counter_4digit;

    logic        clk_50MHz = 1'b0;
    logic        reset_button = 1'b0;
    logic        start_stop = 1'b0;
    logic        up_down = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] bcd;
    logic        running;
    logic        tick;
    logic        carry;

    int checks = 0;
    int failures = 0;

    bcd_counter_4digit #(.TICK_DIV(4)) dut (
        .clk_50MHz   (clk_50MHz),
        .reset_button(reset_button),
        .start_stop  (start_stop),
        .up_down     (up_down),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .bcd         (bcd),
        .running     (running),
        .tick        (tick),
        .carry       (carry)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Advance one edge and settle before sampling.
    task automatic step_clk();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic test_reset();
        reset_button = 1'b1;
        step_clk();
        reset_button = 1'b0;
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
    endtask

    task automatic test_count_up();
        logic [15:0] exp_bcd;
        up_down = 1'b1;
        start_stop = 1'b1;
        step_clk();
        start_stop = 1'b0;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
        exp_bcd = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            if (k == 4) exp_bcd = 16'h0001;
            if (k == 8) exp_bcd = 16'h0002;
            checks++; if (tick !== ((k % 4) == 0)) begin failures++; $display("FAIL count_tick k=%0d got=%b exp=%b", k, tick, (k % 4) == 0); end
            checks++; if (bcd !== exp_bcd) begin failures++; $display("FAIL count_bcd k=%0d got=%h exp=%h", k, bcd, exp_bcd); end
        end
    endtask

    task automatic test_up_wrap();
        up_down = 1'b1;
        load_val = 16'h9998;
        load = 1'b1;
        step_clk();
        load = 1'b0;
        checks++; if (bcd !== 16'h9998) begin failures++; $display("FAIL upwrap_load got=%h exp=9998", bcd); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL upwrap_load_tick got=%b exp=0", tick); end
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            checks++; if (carry !== (k == 8)) begin failures++; $display("FAIL upwrap_carry k=%0d got=%b exp=%b", k, carry, k == 8); end
            if (k == 4) begin
                checks++; if (bcd !== 16'h9999) begin failures++; $display("FAIL upwrap_9999 got=%h exp=9999", bcd); end
            end
        end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL upwrap_0000 got=%h exp=0000", bcd); end
        step_clk();
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL upwrap_carry_drop got=%b exp=0", carry); end
        // Realign the prescaler to 0 for the next scenario.
        for (int k = 0; k < 3; k++) step_clk();
    endtask

    task automatic test_down_wrap();
        up_down = 1'b0;
        load_val = 16'h0001;
        load = 1'b1;
        step_clk();
        load = 1'b0;
        checks++; if (bcd !== 16'h0001) begin failures++; $display("FAIL downwrap_load got=%h exp=0001", bcd); end
        for (int k = 1; k <= 8; k++) begin
            step_clk();
            checks++; if (carry !== (k == 8)) begin failures++; $display("FAIL downwrap_carry k=%0d got=%b exp=%b", k, carry, k == 8); end
            if (k == 4) begin
                checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL downwrap_0000 got=%h exp=0000", bcd); end
            end
        end
        checks++; if (bcd !== 16'h9999) begin failures++; $display("FAIL downwrap_9999 got=%h exp=9999", bcd); end
        for (int k = 0; k < 3; k++) step_clk();
        checks++; if (bcd !== 16'h9999) begin failures++; $display("FAIL downwrap_hold got=%h exp=9999", bcd); end
        // One more step (prescaler was 3) to get back to prescaler 0: 9999 -> 9998.
        step_clk();
        checks++; if (bcd !== 16'h9998) begin failures++; $display("FAIL down_borrow got=%h exp=9998", bcd); end
    endtask

    task automatic test_sanitize();
        up_down = 1'b1;
        load_val = 16'hA5F3;
        load = 1'b1;
        step_clk();
        load = 1'b0;
        checks++; if (bcd !== 16'h9593) begin failures++; $display("FAIL sanitize_load got=%h exp=9593", bcd); end
        for (int k = 1; k <= 4; k++) step_clk();
        checks++; if (bcd !== 16'h9594) begin failures++; $display("FAIL sanitize_step got=%h exp=9594", bcd); end
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL sanitize_tick got=%b exp=1", tick); end
    endtask

    task automatic test_clear_load();
        for (int k = 0; k < 3; k++) step_clk();
        clear = 1'b1;
        load = 1'b1;
        load_val = 16'h1234;
        step_clk();
        clear = 1'b0;
        load = 1'b0;
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL clrld_bcd got=%h exp=0000", bcd); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL clrld_tick got=%b exp=0", tick); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL clrld_carry got=%b exp=0", carry); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL clrld_running got=%b exp=1", running); end
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            checks++; if (tick !== (k == 4)) begin failures++; $display("FAIL clrld_restart_tick k=%0d got=%b exp=%b", k, tick, k == 4); end
        end
        checks++; if (bcd !== 16'h0001) begin failures++; $display("FAIL clrld_next got=%h exp=0001", bcd); end
    endtask

    task automatic test_stop_resume();
        step_clk();
        start_stop = 1'b1;
        step_clk();
        start_stop = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running got=%b exp=0", running); end
        for (int k = 0; k < 10; k++) begin
            step_clk();
            checks++; if (tick !== 1'b0 || bcd !== 16'h0001) begin failures++; $display("FAIL stop_idle k=%0d tick=%b bcd=%h exp tick=0 bcd=0001", k, tick, bcd); end
        end
        start_stop = 1'b1;
        step_clk();
        start_stop = 1'b0;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
        step_clk();
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL resume_early_tick got=%b exp=0", tick); end
        step_clk();
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", tick); end
        checks++; if (bcd !== 16'h0002) begin failures++; $display("FAIL resume_bcd got=%h exp=0002", bcd); end
    endtask

    task automatic test_start_with_clear();
        start_stop = 1'b1;
        clear = 1'b1;
        step_clk();
        start_stop = 1'b0;
        clear = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL startclr_running got=%b exp=0", running); end
        checks++; if (bcd !== 16'h0000) begin failures++; $display("FAIL startclr_bcd got=%h exp=0000", bcd); end
    endtask

    task automatic test_reset_midstep();
        start_stop = 1'b1;
        step_clk();
        start_stop = 1'b0;
        step_clk();
        step_clk();
        reset_button = 1'b1;
        step_clk();
        reset_button = 1'b0;
        checks++; if (running !== 1'b0 || bcd !== 16'h0000) begin failures++; $display("FAIL midreset running=%b bcd=%h exp running=0 bcd=0000", running, bcd); end
        start_stop = 1'b1;
        step_clk();
        start_stop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step_clk();
            checks++; if (tick !== (k == 4)) begin failures++; $display("FAIL midreset_tick k=%0d got=%b exp=%b", k, tick, k == 4); end
        end
        checks++; if (bcd !== 16'h0001) begin failures++; $display("FAIL midreset_bcd got=%h exp=0001", bcd); end
    endtask

    initial begin
        step_clk();
        test_reset();
        test_count_up();
        test_up_wrap();
        test_down_wrap();
        test_sanitize();
        test_clear_load();
        test_stop_resume();
        test_start_with_clear();
        test_reset_midstep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
